// File: rtl/prefetch_writer.sv
// prefetch_writer: producer side of the prefetch queue.
// Fetches aligned 32-bit code words starting at a loaded linear address,
// trims each word to the bytes still inside the segment limit and pushes
// {len[3:0], data[31:0]} entries into the prefetch FIFO. The stream ends
// with a single limit-fault or page-fault entry.
// Optional build macro PREFETCH_WRITER_STATS_EN adds stat_words/stat_stall.
module prefetch_writer #(
  parameter int unsigned STOP_LEVEL = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pr_reset,
  input  logic        prefetch_load,
  input  logic [31:0] prefetch_address,
  input  logic [31:0] prefetch_limit,
  output logic        prefetchread_do,
  output logic [31:0] prefetchread_address,
  input  logic        prefetchread_accept,
  input  logic        prefetchread_done,
  input  logic [31:0] prefetchread_data,
  input  logic        prefetchread_pf,
  input  logic [4:0]  prefetchfifo_used,
  output logic        prefetchfifo_write_do,
  output logic [35:0] prefetchfifo_write_data,
  output logic        prefetchfifo_signal_limit_do,
  output logic        prefetchfifo_signal_pf_do
`ifdef PREFETCH_WRITER_STATS_EN
  ,
  output logic [31:0] stat_words,
  output logic [31:0] stat_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_STOPPED
  } state_t;

  localparam logic [4:0] StopLevel = 5'(STOP_LEVEL);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic        discard_q, discard_d;
  logic        write_do_q, write_do_d;
  logic [35:0] write_data_q, write_data_d;
  logic        limit_do_q, limit_do_d;
  logic        pf_do_q, pf_do_d;

  logic [1:0]  off;
  logic [2:0]  avail;
  logic [2:0]  len;
  logic [31:0] shifted;
  logic [31:0] masked;
  logic        outstanding;
  logic        throttled;

  assign throttled = (prefetchfifo_used >= StopLevel);

  // A read is in flight if we are waiting for a response that has not come
  // yet, or the memory is taking our request in this very cycle.
  assign outstanding = ((state_q == S_WAIT) && !prefetchread_done) ||
                       ((state_q == S_ISSUE) && prefetchread_accept);

  // Trim the returned word: shift the first wanted byte down to byte 0 and
  // zero every byte beyond the in-range length.
  always_comb begin
    off     = addr_q[1:0];
    avail   = 3'd4 - {1'b0, off};
    len     = (remaining_q < {29'd0, avail}) ? remaining_q[2:0] : avail;
    shifted = prefetchread_data >> {off, 3'b000};
    masked  = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < len) begin
        masked[8*i +: 8] = shifted[8*i +: 8];
      end
    end
  end

  // Next-state logic; load and flush override whatever the FSM would do,
  // and load beats flush when both arrive together.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    discard_d    = discard_q;
    write_do_d   = 1'b0;
    write_data_d = write_data_q;
    limit_do_d   = 1'b0;
    pf_do_d      = 1'b0;

    if (prefetchread_done && discard_q) begin
      discard_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
      end
      S_CHECK: begin
        if (remaining_q == 32'd0) begin
          limit_do_d = 1'b1;
          state_d    = S_STOPPED;
        end else if (!throttled && !discard_q) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (prefetchread_accept) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (prefetchread_done && !discard_q) begin
          if (prefetchread_pf) begin
            pf_do_d = 1'b1;
            state_d = S_STOPPED;
          end else begin
            write_do_d   = 1'b1;
            write_data_d = {1'b0, len, masked};
            addr_d       = addr_q + {29'd0, len};
            remaining_d  = remaining_q - {29'd0, len};
            state_d      = S_CHECK;
          end
        end
      end
      S_STOPPED: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (prefetch_load) begin
      state_d     = S_CHECK;
      addr_d      = prefetch_address;
      remaining_d = prefetch_limit;
      write_do_d  = 1'b0;
      limit_do_d  = 1'b0;
      pf_do_d     = 1'b0;
      if (outstanding) begin
        discard_d = 1'b1;
      end
    end else if (pr_reset) begin
      state_d    = S_IDLE;
      write_do_d = 1'b0;
      limit_do_d = 1'b0;
      pf_do_d    = 1'b0;
      if (outstanding) begin
        discard_d = 1'b1;
      end
    end
  end

  // State, address tracking and registered FIFO strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      discard_q    <= 1'b0;
      write_do_q   <= 1'b0;
      write_data_q <= '0;
      limit_do_q   <= 1'b0;
      pf_do_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      discard_q    <= discard_d;
      write_do_q   <= write_do_d;
      write_data_q <= write_data_d;
      limit_do_q   <= limit_do_d;
      pf_do_q      <= pf_do_d;
    end
  end

  assign prefetchread_do              = (state_q == S_ISSUE);
  assign prefetchread_address         = {addr_q[31:2], 2'b00};
  assign prefetchfifo_write_do        = write_do_q;
  assign prefetchfifo_write_data      = write_data_q;
  assign prefetchfifo_signal_limit_do = limit_do_q;
  assign prefetchfifo_signal_pf_do    = pf_do_q;

`ifdef PREFETCH_WRITER_STATS_EN
  logic [31:0] stat_words_q;
  logic [31:0] stat_stall_q;

  // Saturating counters of pushed data entries and FIFO-throttled CHECK cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (write_do_d && (stat_words_q != 32'hFFFF_FFFF)) begin
        stat_words_q <= stat_words_q + 32'd1;
      end
      if ((state_q == S_CHECK) && (remaining_q != 32'd0) && throttled &&
          (stat_stall_q != 32'hFFFF_FFFF)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: doc/prefetch_writer.md
Name: prefetch_writer

Overview:
- Producer side of the prefetch queue. Fetches aligned 32-bit code words from the memory read port, starting at a loaded linear address.
- Trims each word to the bytes that are in range, then pushes {length[3:0], data[31:0]} entries into the prefetch FIFO. Throttles on the FIFO fill level.
- Terminates the stream with a single limit-fault or page-fault signal. Sits between the prefetch address logic and the prefetch FIFO.

Parameters:
- STOP_LEVEL, 15: no new read is issued while prefetchfifo_used >= STOP_LEVEL (range 1..16).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pr_reset  in  1  flush: abandon the current stream and go to IDLE.
- prefetch_load  in  1  one-cycle strobe that starts a new stream.
- prefetch_address  in  32  linear start address, sampled on prefetch_load.
- prefetch_limit  in  32  bytes remaining before the segment limit, sampled on prefetch_load.
- prefetchread_do  out  1  read request; held until accepted.
- prefetchread_address  out  32  word-aligned address; bits [1:0] are always 0.
- prefetchread_accept  in  1  request taken.
- prefetchread_done  in  1  response valid, one cycle.
- prefetchread_data  in  32  response word, little-endian.
- prefetchread_pf  in  1  page fault; qualified by prefetchread_done.
- prefetchfifo_used  in  5  FIFO fill level, 0..16.
- prefetchfifo_write_do  out  1  push a data entry.
- prefetchfifo_write_data  out  36  {len[3:0], data[31:0]}.
- prefetchfifo_signal_limit_do  out  1  push a limit-fault entry.
- prefetchfifo_signal_pf_do  out  1  push a page-fault entry.

Behaviour:
- Reset: all outputs 0; state IDLE; addr, remaining and discard flag cleared.
- Registers:
  - addr[31:0]: current byte address.
  - remaining[31:0]: bytes left before the limit.
  - discard: set when a response is outstanding at the moment of a flush or load.
- Only one read is outstanding at a time.
- States:
  - IDLE: wait for prefetch_load; no requests.
  - CHECK:
    - If remaining == 0: pulse prefetchfifo_signal_limit_do for 1 cycle, go STOPPED.
    - Else if prefetchfifo_used < STOP_LEVEL and discard == 0: go ISSUE.
    - Otherwise stay in CHECK.
  - ISSUE: prefetchread_do = 1, prefetchread_address = {addr[31:2], 2'b00}. On prefetchread_accept, go WAIT (prefetchread_do drops the next cycle).
  - WAIT: on prefetchread_done:
    - If prefetchread_pf: pulse prefetchfifo_signal_pf_do, go STOPPED.
    - Else: push the data entry, update addr and remaining (see Word formatting), go CHECK.
  - STOPPED: idle until prefetch_load or pr_reset.
- Word formatting (all outputs registered, so the push occurs 1 cycle after prefetchread_done):
  - off = addr[1:0]; avail = 4 - off; len = min(avail, remaining).
  - data = prefetchread_data >> (8*off); bytes at index >= len are zeroed.
  - The entry carries len in 1..4.
  - addr += len; remaining -= len. remaining never wraps below 0.
- prefetch_load:
  - Valid in any state. Samples address and limit, then goes to CHECK on the next cycle.
  - If a read is outstanding (WAIT, or ISSUE already accepted), set discard.
  - If in ISSUE and not yet accepted, drop prefetchread_do.
- pr_reset:
  - Goes to IDLE. Sets discard if a read is outstanding.
  - Suppresses any push that would occur in the same cycle.
  - If asserted in the same cycle as prefetch_load, prefetch_load wins.
- Discarded response: prefetchread_done while discard = 1 clears discard and pushes nothing, pf included. CHECK may issue from the next cycle.
- At most one of the three FIFO strobes is active in any cycle. Fault strobes are never repeated within one stream.
- A limit fault takes precedence over issuing a read. A page fault ends the stream even if remaining > 0.

Optional Feature:
- Macro: PREFETCH_WRITER_STATS_EN.
- When defined, adds two outputs, both cleared by rst and both saturating:
  - stat_words[31:0]: count of data entries pushed.
  - stat_stall[31:0]: count of CHECK cycles blocked by prefetchfifo_used >= STOP_LEVEL.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Aligned stream: load addr 0x1000, limit 10; memory returns 0x44332211, 0x88776655, 0xCCBBAA99 → entries {4,0x44332211}, {4,0x88776655}, {2,0x0000AA99}, then a limit-fault pulse; no further read is issued.
- Misaligned start: load addr 0x2003, limit 100; first word 0xDDCCBBAA → entry {1,0x000000DD}; next read address is 0x2004.
- Page fault: second response has prefetchread_pf = 1 → exactly one prefetchfifo_signal_pf_do pulse, no data push, state STOPPED; a new load restarts fetching.
- Throttle: hold prefetchfifo_used = 15 with STOP_LEVEL = 15 → prefetchread_do stays 0; used drops to 14 → request issued on the next cycle.
- Flush mid-read: pr_reset in WAIT, followed by a new load to 0x3000 → the stale response is dropped; the next read is to 0x3000 and is issued only after the stale done arrives.
- Zero limit: load with limit 0 → a single limit-fault pulse 2 cycles after load; prefetchread_do is never asserted.
